// File: rtl/score_display_ctrl.sv
// rtl/score_display_ctrl.sv - binary score to BCD converter with 4-digit multiplexed 7-segment drive
// Double-dabble conversion (one bit per clock) feeding registered digits that a free-running scan displays.
module score_display_ctrl #(
  parameter int B_SIZE   = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [B_SIZE-1:0] fenshu,
  input  logic [3:0]        life,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic [3:0]        fenshu2,
  output logic [3:0]        fenshu1,
  output logic [3:0]        fenshu0,
  output logic [3:0]        shengming,
  output logic [6:0]        seg,
  output logic [3:0]        an
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONV   = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;

  localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(B_SIZE + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] STEP_LAST = CW'(B_SIZE - 1);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     step_q, step_d;
  logic [B_SIZE-1:0] bin_q, bin_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [11:0]       bcd_adj;
  logic [3:0]        life_cap_q, life_cap_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        f2_q, f2_d, f1_q, f1_d, f0_q, f0_d, sheng_q, sheng_d;
  logic [SW-1:0]     scan_q, scan_d;
  logic [1:0]        digit_q, digit_d;

  // Add-3 correction applied before every shift of the double-dabble.
  always_comb begin
    bcd_adj[3:0]  = (bcd_q[3:0]  > 4'd4) ? bcd_q[3:0]  + 4'd3 : bcd_q[3:0];
    bcd_adj[7:4]  = (bcd_q[7:4]  > 4'd4) ? bcd_q[7:4]  + 4'd3 : bcd_q[7:4];
    bcd_adj[11:8] = (bcd_q[11:8] > 4'd4) ? bcd_q[11:8] + 4'd3 : bcd_q[11:8];
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    life_cap_d = life_cap_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    f2_d       = f2_q;
    f1_d       = f1_q;
    f0_d       = f0_q;
    sheng_d    = sheng_q;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          state_d    = S_CONV;
          bin_d      = fenshu;
          life_cap_d = life;
          bcd_d      = '0;
          step_d     = '0;
          busy_d     = 1'b1;
        end
      end
      S_CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        step_d         = step_q + CW'(1);
        if (step_q == STEP_LAST) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        f2_d    = bcd_q[11:8];
        f1_d    = bcd_q[7:4];
        f0_d    = bcd_q[3:0];
        sheng_d = life_cap_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if (scan_q == SCAN_LAST) begin
      scan_d  = '0;
      digit_d = digit_q + 2'd1;
    end else begin
      scan_d  = scan_q + SW'(1);
      digit_d = digit_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      step_q     <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      life_cap_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      f2_q       <= '0;
      f1_q       <= '0;
      f0_q       <= '0;
      sheng_q    <= '0;
      scan_q     <= '0;
      digit_q    <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      life_cap_q <= life_cap_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      f2_q       <= f2_d;
      f1_q       <= f1_d;
      f0_q       <= f0_d;
      sheng_q    <= sheng_d;
      scan_q     <= scan_d;
      digit_q    <= digit_d;
    end
  end

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b0111111;
    endcase
  endfunction

  // Leading-zero blanking on hundreds and tens; units and lives always lit.
  logic [3:0] nib;
  logic       blank;
  always_comb begin
    an    = 4'b1110;
    nib   = f0_q;
    blank = 1'b0;
    case (digit_q)
      2'd1: begin
        an    = 4'b1101;
        nib   = f1_q;
        blank = (f2_q == 4'd0) && (f1_q == 4'd0);
      end
      2'd2: begin
        an    = 4'b1011;
        nib   = f2_q;
        blank = (f2_q == 4'd0);
      end
      2'd3: begin
        an    = 4'b0111;
        nib   = sheng_q;
      end
      default: ;
    endcase
    seg = blank ? 7'b1111111 : seg_of(nib);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign fenshu2   = f2_q;
  assign fenshu1   = f1_q;
  assign fenshu0   = f0_q;
  assign shengming = sheng_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// tb/tb_score_display_ctrl.sv - self-checking bench for score_display_ctrl
// Scoreboard of expected digits plus a reference scan model checking an/seg every cycle.
module tb_score_display_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [7:0] fenshu;
  logic [3:0] life;
  logic       busy, done;
  logic [3:0] fenshu2, fenshu1, fenshu0, shengming;
  logic [6:0] seg;
  logic [3:0] an;

  always #5 clk = ~clk;

  score_display_ctrl #(.B_SIZE(8), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .fenshu(fenshu), .life(life), .load(load),
    .busy(busy), .done(done), .fenshu2(fenshu2), .fenshu1(fenshu1),
    .fenshu0(fenshu0), .shengming(shengming), .seg(seg), .an(an)
  );

  typedef struct {
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] u;
    logic [3:0] l;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       e;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         done_cnt = 0;
  int         d0;
  logic       done_prev = 1'b0;
  logic [3:0] disp_h = 4'd0, disp_t = 4'd0, disp_u = 4'd0, disp_l = 4'd0;
  int         scan_m, dig_m;
  logic [3:0] an_pat [4];
  logic [6:0] seg_pat [4];
  bit         found;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic [3:0] an_ref(input int d);
    case (d)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [6:0] seg_exp(input int d);
    case (d)
      0: return seg_ref(disp_u);
      1: return (disp_h == 4'd0 && disp_t == 4'd0) ? 7'b1111111 : seg_ref(disp_t);
      2: return (disp_h == 4'd0) ? 7'b1111111 : seg_ref(disp_h);
      default: return seg_ref(disp_l);
    endcase
  endfunction

  // Reference scan position: SCAN_DIV=4 clocks per digit from reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_m <= 0;
      dig_m  <= 0;
    end else if (scan_m == 3) begin
      scan_m <= 0;
      dig_m  <= (dig_m + 1) % 4;
    end else begin
      scan_m <= scan_m + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      disp_h = 4'd0; disp_t = 4'd0; disp_u = 4'd0; disp_l = 4'd0;
      done_prev = 1'b0;
    end else begin
      if (done) begin
        done_cnt++;
        chk("done_width", done_prev, 0);
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          disp_h = e.h; disp_t = e.t; disp_u = e.u; disp_l = e.l;
        end
      end
      done_prev = done;
      chk("hold_h", fenshu2, disp_h);
      chk("hold_t", fenshu1, disp_t);
      chk("hold_u", fenshu0, disp_u);
      chk("hold_life", shengming, disp_l);
    end
    chk("an_scan", an, an_ref(dig_m));
    chk("seg_scan", seg, seg_exp(dig_m));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [7:0] f, input logic [3:0] l);
    exp_t x;
    x.h = 4'(f / 100);
    x.t = 4'((f / 10) % 10);
    x.u = 4'(f % 10);
    x.l = l;
    sb_q.push_back(x);
    fenshu = f;
    life   = l;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    fenshu = 8'($urandom);
    life   = 4'($urandom);
  endtask

  task automatic wait_an(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (an == target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; fenshu = 8'd0; life = 4'd0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, 7'b1000000);
    rst_n = 1'b1;
    #1;
    chk("rel_busy", busy, 0);
    chk("rel_done", done, 0);
    chk("rel_digits", {fenshu2, fenshu1, fenshu0, shengming}, 16'h0000);
    chk("rel_an", an, 4'b1110);
    chk("rel_seg", seg, 7'b1000000);
    repeat (2) tick();

    // 255 with life 3: busy E0..E9, done exactly at E9
    d0 = done_cnt;
    start(8'd255, 4'd3);
    chk("busy_e0", busy, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("busy_conv", busy, 1);
      chk("done_early", done, 0);
    end
    tick();
    chk("done_e9", done, 1);
    chk("busy_e9", busy, 0);
    chk("res_255", {fenshu2, fenshu1, fenshu0, shengming}, 16'h2553);
    tick();
    chk("done_e10", done, 0);
    chk("done_cnt_255", done_cnt - d0, 1);

    // second load at E3 must be ignored
    d0 = done_cnt;
    start(8'd123, 4'd1);
    tick(); tick();
    fenshu = 8'd45;
    load   = 1'b1;
    tick();
    load   = 1'b0;
    repeat (6) tick();
    chk("done_123", done, 1);
    chk("res_123", {fenshu2, fenshu1, fenshu0}, 12'h123);
    repeat (12) tick();
    chk("done_cnt_123", done_cnt - d0, 1);
    chk("sb_after_123", sb_q.size(), 0);

    // scan sequence with value 7, life 5
    start(8'd7, 4'd5);
    repeat (9) tick();
    chk("done_7", done, 1);
    an_pat  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_pat = '{7'b1111000, 7'b1111111, 7'b1111111, 7'b0010010};
    wait_an(4'b0111, found);
    chk("scan_find_d3", found, 1);
    wait_an(4'b1110, found);
    chk("scan_find_d0", found, 1);
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        chk("scan_an", an, an_pat[k]);
        chk("scan_seg", seg, seg_pat[k]);
        tick();
      end
    end

    // lives above 9 shown as a dash
    start(8'd88, 4'd12);
    repeat (9) tick();
    chk("done_88", done, 1);
    wait_an(4'b0111, found);
    chk("dash_find", found, 1);
    chk("dash_seg", seg, 7'b0111111);

    // back-to-back: second load at E10 completes at E19
    start(8'd250, 4'd7);
    repeat (9) tick();
    chk("done_b2b_a", done, 1);
    start(8'd9, 4'd0);
    chk("busy_b2b_e10", busy, 1);
    repeat (8) tick();
    chk("done_b2b_e18", done, 0);
    tick();
    chk("done_b2b_e19", done, 1);
    chk("res_b2b", {fenshu2, fenshu1, fenshu0, shengming}, 16'h0090);
    repeat (2) tick();

    // reset at E5 abandons conversion
    d0 = done_cnt;
    start(8'd200, 4'd4);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_digits", {fenshu2, fenshu1, fenshu0, shengming}, 16'h0000);
    chk("mid_rst_an", an, 4'b1110);
    chk("mid_rst_seg", seg, 7'b1000000);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("no_done_after_rst", done_cnt - d0, 0);
    start(8'd200, 4'd4);
    repeat (9) tick();
    chk("done_200", done, 1);
    chk("res_200", {fenshu2, fenshu1, fenshu0, shengming}, 16'h2004);

    // BCD sweep across digit-count boundaries
    foreach (an_pat[i]) ;
    for (int v = 0; v < 8; v++) begin
      logic [7:0] vals [8];
      vals = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd199, 8'd128, 8'd64};
      start(vals[v], 4'(v));
      repeat (9) tick();
      chk("done_sweep", done, 1);
      repeat (3) tick();
    end

    repeat (3) tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/score_display_ctrl.md
SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 SHALL provide parameter B_SIZE, default 8, width of the binary score input.
REQ-002 SHALL provide parameter SCAN_DIV, default 50000, clock cycles each display digit is driven (minimum 2).
REQ-003 SHALL provide port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL provide port fenshu  input  B_SIZE  binary score, sampled only on an accepted load.
REQ-006 SHALL provide port life  input  4  lives count, sampled only on an accepted load.
REQ-007 SHALL provide port load  input  1  conversion request, one-cycle pulse or level.
REQ-008 SHALL provide port busy  output  1  high while a conversion is in progress.
REQ-009 SHALL provide port done  output  1  one-cycle pulse when new digits are registered.
REQ-010 SHALL provide ports fenshu2, fenshu1, fenshu0  output  4 each  registered BCD hundreds, tens, units.
REQ-011 SHALL provide port shengming  output  4  registered lives value.
REQ-012 SHALL provide port seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.
REQ-013 SHALL provide port an  output  4  active-low digit enables, an[0] = rightmost digit.

Function
REQ-014 SHALL implement FSM states IDLE, CONV, UPDATE; IDLE->CONV on load=1, CONV->UPDATE after B_SIZE steps, UPDATE->IDLE unconditionally.
REQ-015 SHALL, at the edge E0 that samples load=1 in IDLE, capture fenshu into a shift register, capture life, clear a 12-bit BCD accumulator, and set busy.
REQ-016 SHALL perform one double-dabble step per CONV edge (E1..E8 for B_SIZE=8): add 3 to each BCD nibble greater than 4, then shift {BCD,bin} left by one bit.
REQ-017 SHALL, at edge E(B_SIZE+1), copy the accumulator nibbles [11:8],[7:4],[3:0] to fenshu2, fenshu1, fenshu0, copy captured life to shengming, pulse done high for exactly one cycle, and clear busy.
REQ-018 SHALL ignore load while busy or in UPDATE; no queuing of requests.
REQ-019 SHALL hold fenshu2/1/0 and shengming unchanged between done pulses regardless of fenshu/life activity.
REQ-020 SHALL accept load=1 in the cycle after UPDATE (back-to-back conversions, period B_SIZE+2 cycles).
REQ-021 SHALL produce correct BCD for every input 0..2^B_SIZE-1; for B_SIZE=8, 255 -> 2,5,5.
REQ-022 SHALL run a scan counter 0..SCAN_DIV-1 continuously, independent of the FSM; on wrap the digit index advances 0->1->2->3->0.
REQ-023 SHALL drive digit 0 = fenshu0 (an=1110), 1 = fenshu1 (1101), 2 = fenshu2 (1011), 3 = shengming (0111); exactly one an bit low at all times.
REQ-024 SHALL encode values 0-9 as standard active-low patterns (0 = 1000000, 1 = 1111001, ... 9 = 0010000).
REQ-025 SHALL show shengming values 10-15 as a dash (seg = 0111111).
REQ-026 SHALL blank (seg = 1111111) digit 2 when fenshu2=0, and digit 1 when fenshu2=0 and fenshu1=0; digit 0 is never blanked.
REQ-027 SHALL derive seg and an only from registered state (no combinational path from inputs).

Reset
REQ-028 SHALL, on rst_n low, immediately force state IDLE, busy=0, done=0, fenshu2/1/0=0, shengming=0, accumulator and shift register 0, scan counter 0, digit index 0.
REQ-029 SHALL, during and after reset until the first scan wrap, drive an=1110 and seg=1000000.
REQ-030 SHALL abandon any in-flight conversion on reset with no done pulse; release requires a new load.

Verification
REQ-031 SHALL verify: rst_n low then high -> busy=0, done=0, digits 0,0,0, shengming=0, an=1110, seg=1000000.
REQ-032 SHALL verify: load with fenshu=255, life=3 -> done high exactly at E9 for one cycle, fenshu2/1/0=2,5,5, shengming=3, busy high E0..E9.
REQ-033 SHALL verify: load fenshu=123, then load fenshu=45 at E3 -> second load ignored, result 1,2,3, single done pulse.
REQ-034 SHALL verify: load fenshu=7 with SCAN_DIV=4 -> an cycles 1110,1101,1011,0111 every 4 clocks; digit 0 seg=1111000, digits 1 and 2 seg=1111111.
REQ-035 SHALL verify: life=12 loaded -> digit 3 seg=0111111; back-to-back load at E10 converts and completes at E19.
REQ-036 SHALL verify: rst_n low at E5 of a conversion of 200 -> all outputs return to reset values, no done pulse, subsequent load of 200 yields 2,0,0.
